// File: rtl/key_expansion_ctrl.sv
// rtl/key_expansion_ctrl.sv - AES key-expansion sequencer: loads Nk key words, then drives one
// FIPS-197 recurrence word per cycle into a 64 x 32 register file (w[i] at register i+1).
module key_expansion_ctrl #(
  parameter logic [5:0] PARK_ADDR = 6'd63
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [1:0]   i_key_len,
  input  logic [255:0] i_key_in,
  output logic [31:0]  o_key_word,
  output logic         o_wr_sel,
  output logic [5:0]   o_addr_wr,
  output logic [5:0]   o_addr_a,
  output logic [5:0]   o_addr_b,
  output logic         o_rot_en,
  output logic         o_sub_en,
  output logic [7:0]   o_rcon,
  output logic [3:0]   o_num_rounds,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_key_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]   r_state;
  logic [5:0]   r_i;
  logic [2:0]   r_j;
  logic [7:0]   r_rcon;
  logic [255:0] r_key;
  logic [1:0]   r_klen;
  logic         r_key_ready;

  logic [2:0]   w_nk_m1;
  logic [5:0]   w_nw_m1;
  logic [255:0] w_key_shift;
  logic [7:0]   w_rcon_next;

  // Key length 2'b11 is folded to 2'b00 when latched, so everything downstream sees three cases.
  always_comb begin
    w_nk_m1      = 3'd3;
    w_nw_m1      = 6'd43;
    o_num_rounds = 4'd10;
    case (r_klen)
      2'b01: begin
        w_nk_m1      = 3'd5;
        w_nw_m1      = 6'd51;
        o_num_rounds = 4'd12;
      end
      2'b10: begin
        w_nk_m1      = 3'd7;
        w_nw_m1      = 6'd59;
        o_num_rounds = 4'd14;
      end
      default: ;
    endcase
  end

  assign w_key_shift = r_key << {r_i[2:0], 5'b0};
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_i         <= 6'd0;
      r_j         <= 3'd0;
      r_rcon      <= 8'h01;
      r_key       <= 256'd0;
      r_klen      <= 2'b00;
      r_key_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_key       <= i_key_in;
            r_klen      <= (i_key_len == 2'b11) ? 2'b00 : i_key_len;
            r_i         <= 6'd0;
            r_rcon      <= 8'h01;
            r_key_ready <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_i <= r_i + 6'd1;
          if (r_i == {3'b000, w_nk_m1}) begin
            r_j     <= 3'd0;
            r_state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          r_i <= r_i + 6'd1;
          r_j <= (r_j == w_nk_m1) ? 3'd0 : r_j + 3'd1;
          if (r_j == 3'd0) begin
            r_rcon <= w_rcon_next;
          end
          if (r_i == w_nw_m1) begin
            r_key_ready <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outside LOAD/EXPAND the write port is parked on the scratch register.
  always_comb begin
    o_key_word = 32'd0;
    o_wr_sel   = 1'b0;
    o_addr_wr  = PARK_ADDR;
    o_addr_a   = 6'd0;
    o_addr_b   = 6'd0;
    o_rot_en   = 1'b0;
    o_sub_en   = 1'b0;
    o_rcon     = 8'h00;
    case (r_state)
      S_LOAD: begin
        o_key_word = w_key_shift[255:224];
        o_addr_wr  = r_i + 6'd1;
      end
      S_EXPAND: begin
        o_wr_sel  = 1'b1;
        o_addr_wr = r_i + 6'd1;
        o_addr_a  = r_i - {3'b000, w_nk_m1};
        o_addr_b  = r_i;
        if (r_j == 3'd0) begin
          o_rot_en = 1'b1;
          o_sub_en = 1'b1;
          o_rcon   = r_rcon;
        end else if (r_klen == 2'b10 && r_j == 3'd4) begin
          o_sub_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_busy      = (r_state == S_LOAD) || (r_state == S_EXPAND);
  assign o_done      = (r_state == S_DONE);
  assign o_key_ready = r_key_ready;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// tb/tb_key_expansion_ctrl.sv - directed bench for key_expansion_ctrl with a behavioural
// register file and word datapath attached.
module tb_key_expansion_ctrl;

  logic         clk;
  logic         i_rst;
  logic         i_start;
  logic [1:0]   i_key_len;
  logic [255:0] i_key_in;
  logic [31:0]  o_key_word;
  logic         o_wr_sel;
  logic [5:0]   o_addr_wr;
  logic [5:0]   o_addr_a;
  logic [5:0]   o_addr_b;
  logic         o_rot_en;
  logic         o_sub_en;
  logic [7:0]   o_rcon;
  logic [3:0]   o_num_rounds;
  logic         o_busy;
  logic         o_done;
  logic         o_key_ready;

  key_expansion_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_key_len(i_key_len), .i_key_in(i_key_in),
    .o_key_word(o_key_word), .o_wr_sel(o_wr_sel), .o_addr_wr(o_addr_wr), .o_addr_a(o_addr_a),
    .o_addr_b(o_addr_b), .o_rot_en(o_rot_en), .o_sub_en(o_sub_en), .o_rcon(o_rcon),
    .o_num_rounds(o_num_rounds), .o_busy(o_busy), .o_done(o_done), .o_key_ready(o_key_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file and word datapath that sit outside the sequencer.
  logic [7:0]  sbox [0:255];
  logic [31:0] mem  [0:63];
  logic [31:0] gold [0:63];
  logic [31:0] dp_t;
  logic [31:0] dp_new;
  logic        mem_clr;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      logic [7:0] av;
      av  = a[7:0];
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(av, c[7:0]) == 8'h01) inv = c[7:0];
      end
      sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  end

  always_comb begin
    dp_t = mem[o_addr_b];
    if (o_rot_en) dp_t = {dp_t[23:0], dp_t[31:24]};
    if (o_sub_en) dp_t = {sbox[dp_t[31:24]], sbox[dp_t[23:16]], sbox[dp_t[15:8]], sbox[dp_t[7:0]]};
    dp_t   = dp_t ^ {o_rcon, 24'h0};
    dp_new = mem[o_addr_a] ^ dp_t;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'd0;
    end else begin
      mem[o_addr_wr] <= o_wr_sel ? dp_new : o_key_word;
    end
  end

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-cycle log of one run; index = cycle number after the Start edge.
  logic [5:0] l_wr  [0:127];
  logic [5:0] l_a   [0:127];
  logic [5:0] l_b   [0:127];
  logic       l_rot [0:127];
  logic       l_sub [0:127];
  logic [7:0] l_rc  [0:127];
  logic       l_bsy [0:127];
  logic       l_kr  [0:127];
  logic [7:0] rcon_q[$];
  int         rot_q[$];
  int         done_cyc;
  int         n_done;
  int         bad_addr;

  task automatic run(input logic [1:0] len, input logic [255:0] key,
                     input int s1, input int s2, input int s3, input int rst_at);
    @(negedge clk);
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr   = 1'b0;
    i_start   = 1'b1;
    i_key_len = len;
    i_key_in  = key;
    @(negedge clk);
    i_start   = 1'b0;
    i_key_in  = ~key;
    i_key_len = len ^ 2'b10;
    done_cyc  = 0;
    n_done    = 0;
    bad_addr  = 0;
    rcon_q.delete();
    rot_q.delete();
    for (int cyc = 1; cyc <= 70; cyc++) begin
      l_wr[cyc]  = o_addr_wr;
      l_a[cyc]   = o_addr_a;
      l_b[cyc]   = o_addr_b;
      l_rot[cyc] = o_rot_en;
      l_sub[cyc] = o_sub_en;
      l_rc[cyc]  = o_rcon;
      l_bsy[cyc] = o_busy;
      l_kr[cyc]  = o_key_ready;
      if (o_busy && (o_addr_wr == 6'd63 || o_addr_wr > 6'd60)) bad_addr++;
      if (!o_busy && o_addr_wr != 6'd63) bad_addr++;
      if (o_rcon != 8'h00) rcon_q.push_back(o_rcon);
      if (o_rot_en) rot_q.push_back(int'(o_addr_b));
      if (o_done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      i_start = (cyc == s1) || (cyc == s2) || (cyc == s3);
      i_rst   = (cyc == rst_at);
      @(negedge clk);
    end
    i_start = 1'b0;
    i_rst   = 1'b0;
  endtask

  logic [255:0] k128;
  logic [255:0] k192;
  logic [255:0] k256;
  logic [7:0]   exp_rc [0:9];
  int           bad;

  initial begin
    checks    = 0;
    failures  = 0;
    mem_clr   = 1'b0;
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_key_len = 2'b00;
    i_key_in  = 256'd0;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    exp_rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    repeat (3) @(negedge clk);
    i_rst = 1'b0;

    chk("rst_addr_wr", {26'd0, o_addr_wr}, 32'd63);
    chk("rst_addr_ab", {20'd0, o_addr_a, o_addr_b}, 32'd0);
    chk("rst_flags", {25'd0, o_busy, o_done, o_key_ready, o_wr_sel, o_rot_en, o_sub_en, 1'b0}, 32'd0);
    chk("rst_rcon_kw", {o_rcon, 24'd0} | o_key_word, 32'd0);
    chk("rst_rounds", {28'd0, o_num_rounds}, 32'd10);

    // AES-128 baseline
    run(2'b00, k128, 0, 0, 0, 0);
    chk("a128_reg5", mem[5], 32'ha0fafe17);
    chk("a128_reg44", mem[44], 32'hb6630ca6);
    chk("a128_done_cyc", done_cyc, 45);
    chk("a128_n_done", n_done, 1);
    chk("a128_i4_addr", {8'd0, 2'd0, l_wr[5], 2'd0, l_a[5], 2'd0, l_b[5]}, {8'd0, 8'd5, 8'd1, 8'd4});
    chk("a128_i4_ctl", {22'd0, l_rot[5], l_sub[5], l_rc[5]}, {22'd0, 2'b11, 8'h01});
    bad = (rcon_q.size() == 10) ? 0 : 100;
    for (int k = 0; k < 10 && k < rcon_q.size(); k++) if (rcon_q[k] !== exp_rc[k]) bad++;
    chk("a128_rcon_seq", bad, 0);
    chk("a128_addr_range", bad_addr, 0);
    chk("a128_key_ready", {31'd0, o_key_ready}, 32'd1);
    for (int k = 0; k < 64; k++) gold[k] = mem[k];

    // AES-192; Start from IDLE with Key_Ready high must drop it
    run(2'b01, k192, 0, 0, 0, 0);
    chk("a192_kr_drop", {31'd0, l_kr[1]}, 32'd0);
    chk("a192_reg52", mem[52], 32'h01002202);
    chk("a192_rounds", {28'd0, o_num_rounds}, 32'd12);
    chk("a192_done_cyc", done_cyc, 53);
    bad = (rot_q.size() == 8) ? 0 : 100;
    for (int k = 0; k < 8 && k < rot_q.size(); k++) if (rot_q[k] != 6 * (k + 1)) bad++;
    chk("a192_rot_cycles", bad, 0);
    chk("a192_addr_range", bad_addr, 0);

    // AES-256
    run(2'b10, k256, 0, 0, 0, 0);
    chk("a256_reg60", mem[60], 32'h706c631e);
    chk("a256_rounds", {28'd0, o_num_rounds}, 32'd14);
    chk("a256_done_cyc", done_cyc, 61);
    chk("a256_i12_ctl", {22'd0, l_rot[13], l_sub[13], l_rc[13]}, {22'd0, 2'b01, 8'h00});
    chk("a256_i12_addr", {8'd0, 2'd0, l_wr[13], 2'd0, l_a[13], 2'd0, l_b[13]}, {8'd0, 8'd13, 8'd5, 8'd12});
    chk("a256_addr_range", bad_addr, 0);

    // AES-128 with Start pulses while busy and during DONE
    run(2'b00, k128, 3, 20, 45, 0);
    chk("dist_n_done", n_done, 1);
    chk("dist_done_cyc", done_cyc, 45);
    chk("dist_after_done", {30'd0, l_bsy[46], l_kr[46]}, 32'd1);
    bad = 0;
    for (int k = 1; k <= 44; k++) if (mem[k] !== gold[k]) bad++;
    chk("dist_regs", bad, 0);

    // Reset mid-run, then a clean run
    run(2'b00, k128, 0, 0, 0, 10);
    chk("rst_mid_busy", {31'd0, l_bsy[11]}, 32'd0);
    chk("rst_mid_addr", {26'd0, l_wr[11]}, 32'd63);
    chk("rst_mid_kr", {31'd0, l_kr[11]}, 32'd0);
    chk("rst_mid_no_done", n_done, 0);
    run(2'b00, k128, 0, 0, 0, 0);
    chk("rst_rerun_done", done_cyc, 45);
    chk("rst_rerun_reg44", mem[44], 32'hb6630ca6);

    // Key_Len=11 behaves as 128-bit, and idle cycles leave the file alone
    run(2'b11, k128, 0, 0, 0, 0);
    chk("kl11_done_cyc", done_cyc, 45);
    chk("kl11_rounds", {28'd0, o_num_rounds}, 32'd10);
    bad = 0;
    for (int k = 1; k <= 60; k++) if (mem[k] !== gold[k]) bad++;
    chk("kl11_regs", bad, 0);
    bad = 0;
    for (int k = 0; k < 64; k++) gold[k] = mem[k];
    repeat (10) begin
      @(negedge clk);
      if (o_addr_wr != 6'd63 || o_busy) bad++;
    end
    for (int k = 1; k <= 60; k++) if (mem[k] !== gold[k]) bad++;
    chk("idle_untouched", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
